if_stage_ctrl: RTL and testbench

- Consumer end of the hazard-control interface. Applies the `stall`, `flush` and `branch_taken` decisions to the front of the non-forwarding pipeline.
- Owns the PC register, the next-PC selection and the IF/ID pipeline register: redirects on taken branches and jumps, freezes on stalls, and injects NOPs on flushes.
- Keeps saturating stall and flush performance counters.
- Sits between instruction memory and the decode stage.

---
 rtl/if_stage_ctrl.sv | 102 ++++++++++
 tb/tb_if_stage_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/if_stage_ctrl.sv
// Fetch-stage controller: PC register, next-PC selection and IF/ID register,
// steered by the stall/flush/branch decisions from the hazard unit.
module if_stage_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             branch_taken,
    input  logic [31:0]      br_target,
    input  logic [31:0]      imem_instr,
    output logic [31:0]      pc_if,
    output logic [31:0]      IF_ID_pc,
    output logic [31:0]      IF_ID_instr,
    output logic             IF_ID_valid,
    output logic             misalign_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      id_pc_q, id_pc_d;
    logic [31:0]      id_instr_q, id_instr_d;
    logic             id_valid_q, id_valid_d;
    logic             misalign_q, misalign_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic        redirect;
    logic        hold;
    logic [31:0] pc_seq;
    logic [31:0] pc_target;

    assign redirect  = branch_taken | flush;
    assign hold      = stall & ~redirect;
    assign pc_seq    = pc_q + 32'd4;
    // Low two bits are dropped unconditionally; this also covers the JALR LSB clear.
    assign pc_target = {br_target[31:2], 2'b00};

    always_comb begin
        pc_d       = pc_q;
        id_pc_d    = id_pc_q;
        id_instr_d = id_instr_q;
        id_valid_d = id_valid_q;
        if (redirect) begin
            // A redirect squashes whatever is in IF, even if a stall was also requested.
            pc_d       = branch_taken ? pc_target : pc_seq;
            id_pc_d    = pc_q;
            id_instr_d = NOP_INSTR;
            id_valid_d = 1'b0;
        end else if (!stall) begin
            pc_d       = pc_seq;
            id_pc_d    = pc_q;
            id_instr_d = imem_instr;
            id_valid_d = 1'b1;
        end
    end

    always_comb begin
        misalign_d  = misalign_q | (branch_taken & br_target[1]);
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hold && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (redirect && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            id_pc_q     <= 32'h0000_0000;
            id_instr_q  <= NOP_INSTR;
            id_valid_q  <= 1'b0;
            misalign_q  <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            id_pc_q     <= id_pc_d;
            id_instr_q  <= id_instr_d;
            id_valid_q  <= id_valid_d;
            misalign_q  <= misalign_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign pc_if        = pc_q;
    assign IF_ID_pc     = id_pc_q;
    assign IF_ID_instr  = id_instr_q;
    assign IF_ID_valid  = id_valid_q;
    assign misalign_err = misalign_q;
    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_if_stage_ctrl.sv
// Directed bench for if_stage_ctrl: a default build plus a narrow-counter
// build for saturation.
module tb_if_stage_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, stall, flush, branch_taken;
    logic [31:0] br_target, imem_instr;
    logic [31:0] pc_if, IF_ID_pc, IF_ID_instr;
    logic        IF_ID_valid, misalign_err;
    logic [31:0] stall_cnt, flush_cnt;

    logic        stall_s, flush_s;
    logic [31:0] pc_if_s, id_pc_s, id_instr_s;
    logic        id_valid_s, misalign_s;
    logic [3:0]  stall_cnt_s, flush_cnt_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_of(input logic [31:0] pc);
        return 32'h0050_0093 + (pc << 8);
    endfunction

    assign imem_instr = imem_of(pc_if);

    if_stage_ctrl dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .br_target(br_target), .imem_instr(imem_instr),
        .pc_if(pc_if), .IF_ID_pc(IF_ID_pc), .IF_ID_instr(IF_ID_instr),
        .IF_ID_valid(IF_ID_valid), .misalign_err(misalign_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    if_stage_ctrl #(.CNT_W(4)) dut_s (
        .clk(clk), .reset(reset), .stall(stall_s), .flush(flush_s),
        .branch_taken(1'b0), .br_target(32'h0), .imem_instr(NOP),
        .pc_if(pc_if_s), .IF_ID_pc(id_pc_s), .IF_ID_instr(id_instr_s),
        .IF_ID_valid(id_valid_s), .misalign_err(misalign_s),
        .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0;
        br_target = 32'h0; stall_s = 1'b0; flush_s = 1'b0;
        step(); step();
        n_checks++; if (pc_if !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h exp %h", pc_if, 32'h0); end
        n_checks++; if (IF_ID_pc !== 32'h0) begin n_fail++; $display("FAIL reset_id_pc got %h exp %h", IF_ID_pc, 32'h0); end
        n_checks++; if (IF_ID_instr !== NOP) begin n_fail++; $display("FAIL reset_instr got %h exp %h", IF_ID_instr, NOP); end
        n_checks++; if (IF_ID_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", IF_ID_valid); end
        n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset_misalign got %b exp 0", misalign_err); end
        n_checks++; if (stall_cnt !== 32'h0 || flush_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_cnts got %0d/%0d exp 0/0", stall_cnt, flush_cnt); end
        reset = 1'b0;
    endtask

    task automatic test_advance();
        step();
        n_checks++; if (IF_ID_instr !== 32'h0050_0093) begin n_fail++; $display("FAIL adv1_instr got %h exp %h", IF_ID_instr, 32'h0050_0093); end
        n_checks++; if (IF_ID_pc !== 32'h0) begin n_fail++; $display("FAIL adv1_id_pc got %h exp 0", IF_ID_pc); end
        n_checks++; if (IF_ID_valid !== 1'b1) begin n_fail++; $display("FAIL adv1_valid got %b exp 1", IF_ID_valid); end
        n_checks++; if (pc_if !== 32'd4) begin n_fail++; $display("FAIL adv1_pc got %h exp 4", pc_if); end
        step();
        n_checks++; if (pc_if !== 32'd8) begin n_fail++; $display("FAIL adv2_pc got %h exp 8", pc_if); end
        n_checks++; if (IF_ID_pc !== 32'd4 || IF_ID_instr !== imem_of(32'd4)) begin n_fail++; $display("FAIL adv2_id got %h/%h exp %h/%h", IF_ID_pc, IF_ID_instr, 32'd4, imem_of(32'd4)); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            n_checks++; if (pc_if !== 32'd8) begin n_fail++; $display("FAIL stall_pc[%0d] got %h exp 8", i, pc_if); end
            n_checks++; if (IF_ID_pc !== 32'd4 || IF_ID_instr !== imem_of(32'd4) || IF_ID_valid !== 1'b1) begin
                n_fail++; $display("FAIL stall_id[%0d] got %h/%h/%b exp %h/%h/1", i, IF_ID_pc, IF_ID_instr, IF_ID_valid, 32'd4, imem_of(32'd4)); end
            n_checks++; if (stall_cnt !== 32'(i)) begin n_fail++; $display("FAIL stall_cnt[%0d] got %0d exp %0d", i, stall_cnt, i); end
        end
        stall = 1'b0;
        step();
        n_checks++; if (pc_if !== 32'd12) begin n_fail++; $display("FAIL unstall_pc got %h exp c", pc_if); end
        n_checks++; if (IF_ID_pc !== 32'd8 || IF_ID_instr !== imem_of(32'd8)) begin n_fail++; $display("FAIL unstall_id got %h/%h exp 8/%h", IF_ID_pc, IF_ID_instr, imem_of(32'd8)); end
        n_checks++; if (stall_cnt !== 32'd3) begin n_fail++; $display("FAIL unstall_cnt got %0d exp 3", stall_cnt); end
        step();
        n_checks++; if (pc_if !== 32'd16) begin n_fail++; $display("FAIL pre_branch_pc got %h exp 10", pc_if); end
    endtask

    task automatic test_redirect();
        branch_taken = 1'b1; flush = 1'b1; br_target = 32'h40;
        step();
        branch_taken = 1'b0; flush = 1'b0;
        n_checks++; if (pc_if !== 32'h40) begin n_fail++; $display("FAIL br_pc got %h exp 40", pc_if); end
        n_checks++; if (IF_ID_instr !== NOP || IF_ID_valid !== 1'b0) begin n_fail++; $display("FAIL br_nop got %h/%b exp %h/0", IF_ID_instr, IF_ID_valid, NOP); end
        n_checks++; if (IF_ID_pc !== 32'd16) begin n_fail++; $display("FAIL br_id_pc got %h exp 10", IF_ID_pc); end
        n_checks++; if (flush_cnt !== 32'd1) begin n_fail++; $display("FAIL br_flush_cnt got %0d exp 1", flush_cnt); end
        step();
        n_checks++; if (IF_ID_pc !== 32'h40 || IF_ID_valid !== 1'b1 || IF_ID_instr !== imem_of(32'h40)) begin
            n_fail++; $display("FAIL br_target_id got %h/%b/%h exp 40/1/%h", IF_ID_pc, IF_ID_valid, IF_ID_instr, imem_of(32'h40)); end
        n_checks++; if (pc_if !== 32'h44) begin n_fail++; $display("FAIL br_next_pc got %h exp 44", pc_if); end
    endtask

    task automatic test_stall_redirect();
        stall = 1'b1; branch_taken = 1'b1; flush = 1'b1; br_target = 32'h101;
        step();
        stall = 1'b0; branch_taken = 1'b0; flush = 1'b0;
        n_checks++; if (pc_if !== 32'h100) begin n_fail++; $display("FAIL sr_pc got %h exp 100", pc_if); end
        n_checks++; if (stall_cnt !== 32'd3) begin n_fail++; $display("FAIL sr_stall_cnt got %0d exp 3", stall_cnt); end
        n_checks++; if (flush_cnt !== 32'd2) begin n_fail++; $display("FAIL sr_flush_cnt got %0d exp 2", flush_cnt); end
        n_checks++; if (IF_ID_valid !== 1'b0 || IF_ID_pc !== 32'h44) begin n_fail++; $display("FAIL sr_id got %b/%h exp 0/44", IF_ID_valid, IF_ID_pc); end
        n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL sr_bit0_misalign got %b exp 0", misalign_err); end
    endtask

    task automatic test_flush_only();
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_checks++; if (pc_if !== 32'h104) begin n_fail++; $display("FAIL fo_pc got %h exp 104", pc_if); end
        n_checks++; if (IF_ID_valid !== 1'b0 || IF_ID_instr !== NOP || IF_ID_pc !== 32'h100) begin
            n_fail++; $display("FAIL fo_id got %b/%h/%h exp 0/%h/100", IF_ID_valid, IF_ID_instr, IF_ID_pc, NOP); end
        n_checks++; if (flush_cnt !== 32'd3) begin n_fail++; $display("FAIL fo_flush_cnt got %0d exp 3", flush_cnt); end
    endtask

    task automatic test_misalign();
        branch_taken = 1'b1; flush = 1'b1; br_target = 32'h46;
        step();
        branch_taken = 1'b0; flush = 1'b0;
        n_checks++; if (pc_if !== 32'h44) begin n_fail++; $display("FAIL mis_pc got %h exp 44", pc_if); end
        n_checks++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL mis_set got %b exp 1", misalign_err); end
        for (int i = 0; i < 5; i++) step();
        n_checks++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL mis_sticky got %b exp 1", misalign_err); end
        n_checks++; if (pc_if !== 32'h58) begin n_fail++; $display("FAIL mis_run_pc got %h exp 58", pc_if); end
    endtask

    task automatic test_reset_mid_redirect();
        reset = 1'b1; stall = 1'b1; branch_taken = 1'b1; flush = 1'b1; br_target = 32'h200;
        step();
        reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; flush = 1'b0;
        n_checks++; if (pc_if !== 32'h0) begin n_fail++; $display("FAIL rr_pc got %h exp 0", pc_if); end
        n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL rr_misalign got %b exp 0", misalign_err); end
        n_checks++; if (stall_cnt !== 32'h0 || flush_cnt !== 32'h0) begin n_fail++; $display("FAIL rr_cnts got %0d/%0d exp 0/0", stall_cnt, flush_cnt); end
        n_checks++; if (IF_ID_valid !== 1'b0 || IF_ID_instr !== NOP) begin n_fail++; $display("FAIL rr_id got %b/%h exp 0/%h", IF_ID_valid, IF_ID_instr, NOP); end
    endtask

    task automatic test_pc_wrap();
        branch_taken = 1'b1; flush = 1'b1; br_target = 32'hFFFF_FFFC;
        step();
        branch_taken = 1'b0; flush = 1'b0;
        n_checks++; if (pc_if !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pre_pc got %h exp fffffffc", pc_if); end
        step();
        n_checks++; if (pc_if !== 32'h0) begin n_fail++; $display("FAIL wrap_pc got %h exp 0", pc_if); end
        n_checks++; if (IF_ID_pc !== 32'hFFFF_FFFC || IF_ID_instr !== imem_of(32'hFFFF_FFFC)) begin
            n_fail++; $display("FAIL wrap_id got %h/%h exp fffffffc/%h", IF_ID_pc, IF_ID_instr, imem_of(32'hFFFF_FFFC)); end
        n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL wrap_misalign got %b exp 0", misalign_err); end
    endtask

    task automatic test_saturate();
        logic [3:0] exp_s;
        logic [31:0] pc_hold;
        stall_s = 1'b1;
        step();
        pc_hold = pc_if_s;
        for (int i = 2; i <= 20; i++) begin
            step();
            exp_s = (i >= 15) ? 4'hF : 4'(i);
            n_checks++; if (stall_cnt_s !== exp_s) begin n_fail++; $display("FAIL sat_stall[%0d] got %h exp %h", i, stall_cnt_s, exp_s); end
        end
        n_checks++; if (pc_if_s !== pc_hold) begin n_fail++; $display("FAIL sat_pc_hold got %h exp %h", pc_if_s, pc_hold); end
        stall_s = 1'b0; flush_s = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            exp_s = (i >= 15) ? 4'hF : 4'(i);
            n_checks++; if (flush_cnt_s !== exp_s) begin n_fail++; $display("FAIL sat_flush[%0d] got %h exp %h", i, flush_cnt_s, exp_s); end
        end
        flush_s = 1'b0;
        n_checks++; if (stall_cnt_s !== 4'hF) begin n_fail++; $display("FAIL sat_stall_keep got %h exp f", stall_cnt_s); end
        n_checks++; if (pc_if_s !== pc_hold + 32'd80) begin n_fail++; $display("FAIL sat_flush_pc got %h exp %h", pc_if_s, pc_hold + 32'd80); end
    endtask

    initial begin
        test_reset();
        test_advance();
        test_stall();
        test_redirect();
        test_stall_redirect();
        test_flush_only();
        test_misalign();
        test_reset_mid_redirect();
        test_pc_wrap();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
